the_wb_stage: RTL
=================

# the_wb_stage

Registered write-back stage between the MEM stage and the register file. Latches the MEM/WB bundle (control, read data, ALU result, destination register), selects the write-back value, and drives the register-file write port. Maintains a retired-write counter. Optionally maintains a write-back trace FIFO for bench and debug readout.

## Interface
- `CNT_W`, default 32: width of the retired-write counter.
- `TRACE_DEPTH`, default 8: trace FIFO entries; must be a power of two, 2..64.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `mem_control_wb`  in  2  bit1 = RegWrite, bit0 = MemtoReg.
- `mem_Read_data`  in  32  data-memory read value.
- `mem_ALU_result`  in  32  ALU result.
- `mem_Write_reg`  in  5  destination register.
- `wb_stall`  in  1  hold the current WB contents.
- `wb_flush`  in  1  load a bubble.
- `wb_RegWrite`  out  1  register-file write enable.
- `wb_WriteReg`  out  5  register-file write address.
- `wb_WriteData`  out  32  register-file write data.
- `retire_count`  out  CNT_W  number of committed register writes.
- `trace_rd_en`  in  1  pop one trace entry.
- `trace_data`  out  37  {reg[4:0], data[31:0]} at the FIFO head.
- `trace_empty`  out  1  FIFO empty.
- `trace_full`  out  1  FIFO full.
- `trace_overflow`  out  1  sticky; set when a push is dropped.

## Operation
- Selected value `sel` = MemtoReg ? `mem_Read_data` : `mem_ALU_result`.
- Effective write `ew` = RegWrite && (`mem_Write_reg` != 0). A write to $zero is never committed.
- Each rising edge, priority flush > stall > load:
  - **flush:** `wb_RegWrite` <= 0. `wb_WriteReg` and `wb_WriteData` <= 0. No count, no push.
  - **stall (no flush):** all WB outputs hold. No count, no push.
  - **load:** `wb_RegWrite` <= `ew`, `wb_WriteReg` <= `mem_Write_reg`, `wb_WriteData` <= `sel`.
    - If `ew`: `retire_count` increments by 1 and the FIFO is pushed with {`mem_Write_reg`, `sel`}.
- `retire_count` wraps from 2^CNT_W-1 to 0 with no flag.
- Trace FIFO:
  - Circular buffer with read pointer, write pointer and occupancy count 0..TRACE_DEPTH.
  - `trace_data` is the head entry, combinational from storage. It reads 0 when empty.
  - **Pop:** `trace_rd_en` && !empty advances the read pointer. `trace_rd_en` while empty is ignored.
  - **Push while not full:** stores the entry and advances the write pointer.
  - **Push and pop in the same edge:** both happen and occupancy is unchanged. This applies even when full, because the pop frees the slot.
  - **Push while full, no pop:** the entry is dropped and `trace_overflow` <= 1. It stays set until `reset`.
  - Pointers wrap modulo TRACE_DEPTH.

## Timing
- Latency is 1 cycle: MEM inputs sampled at edge N appear on the WB outputs after edge N.
- `retire_count` and FIFO occupancy update on the same edge as the WB outputs.
- `trace_empty` and `trace_full` are registered-state derived and valid in the same cycle as the pointer update.
- `reset` asserted at any time, including mid-stall or with the FIFO partly filled, immediately sets:
  - `wb_RegWrite`=0, `wb_WriteReg`=0, `wb_WriteData`=0;
  - `retire_count`=0;
  - FIFO pointers and occupancy = 0, so `trace_empty`=1, `trace_full`=0, `trace_data`=0;
  - `trace_overflow`=0.
  
  The first load after deassertion occurs at the first rising edge with `reset` low.
- `wb_stall` and `wb_flush` do not affect FIFO pops. Readout continues during a pipeline stall.

## Configuration
- **`WB_TRACE_EN` defined:** the trace FIFO is built as described.
- **`WB_TRACE_EN` undefined:** no FIFO storage is built. Outputs are constant:
  - `trace_data`=0, `trace_empty`=1, `trace_full`=0, `trace_overflow`=0;
  - `trace_rd_en` is ignored.
  
  Write-back path and `retire_count` are unchanged.

## Test plan
- **Basic loads:** RegWrite=1, MemtoReg=0, ALU=0x0000_00A5, reg=8 -> next cycle `wb_RegWrite`=1, `wb_WriteReg`=8, `wb_WriteData`=0xA5, `retire_count`=1. Then MemtoReg=1, Read_data=0xDEAD_BEEF -> data 0xDEADBEEF, count 2.
- **$zero suppression:** RegWrite=1, reg=0, ALU=0x1234 -> `wb_RegWrite`=0, `wb_WriteData`=0x1234, count unchanged, no FIFO push.
- **Stall and flush:** load reg=3, then 2 cycles of `wb_stall`=1 with new inputs -> outputs stay reg=3 and count increments once. Then `wb_flush`=1 together with `wb_stall`=1 -> `wb_RegWrite`=0 and data 0.
- **FIFO fill and overflow (TRACE_DEPTH=8, `WB_TRACE_EN`):** 9 consecutive writes to regs 1..9, no pops -> `trace_full`=1, `trace_overflow`=1, head = {1, data1}. Then 8 pops return regs 1..8 in order, then `trace_empty`=1.
- **Simultaneous push/pop when full:** push with `trace_rd_en`=1 -> occupancy stays 8, `trace_overflow` unchanged, newest entry present.
- **Reset mid-operation:** assert `reset` asynchronously between edges with count=5 and FIFO holding 3 entries -> all outputs at reset values before the next edge. After release, count restarts at 0 on the first committed write.

Source files
------------

// File: rtl/the_wb_stage_if.sv
// MEM/WB bundle between the memory stage and the write-back stage.
// master = MEM-side driver, slave = the write-back stage.
interface the_wb_stage_if;
  logic [1:0]  mem_control_wb;
  logic [31:0] mem_Read_data;
  logic [31:0] mem_ALU_result;
  logic [4:0]  mem_Write_reg;
  logic        wb_stall;
  logic        wb_flush;
  logic        wb_RegWrite;
  logic [4:0]  wb_WriteReg;
  logic [31:0] wb_WriteData;

  modport master (
    output mem_control_wb,
    output mem_Read_data,
    output mem_ALU_result,
    output mem_Write_reg,
    output wb_stall,
    output wb_flush,
    input  wb_RegWrite,
    input  wb_WriteReg,
    input  wb_WriteData
  );

  modport slave (
    input  mem_control_wb,
    input  mem_Read_data,
    input  mem_ALU_result,
    input  mem_Write_reg,
    input  wb_stall,
    input  wb_flush,
    output wb_RegWrite,
    output wb_WriteReg,
    output wb_WriteData
  );
endinterface

// File: rtl/the_wb_stage.sv
// Registered write-back stage with retired-write counter.
// Define WB_TRACE_EN to build the write-back trace FIFO; otherwise trace outputs are constant.
module the_wb_stage #(
  parameter int CNT_W       = 32,
  parameter int TRACE_DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  the_wb_stage_if.slave    wb,
  output logic [CNT_W-1:0] retire_count,
  input  logic             trace_rd_en,
  output logic [36:0]      trace_data,
  output logic             trace_empty,
  output logic             trace_full,
  output logic             trace_overflow
);
  localparam int DATA_W  = 32;
  localparam int REG_W   = 5;
  localparam int TRACE_W = REG_W + DATA_W;

  logic [DATA_W-1:0] sel_p0;
  logic              ew_p0;
  logic              load_p0;
  logic              push_p0;

  always_comb begin
    sel_p0  = wb.mem_control_wb[0] ? wb.mem_Read_data : wb.mem_ALU_result;
    ew_p0   = wb.mem_control_wb[1] && (wb.mem_Write_reg != '0);
    load_p0 = !wb.wb_flush && !wb.wb_stall;
    push_p0 = load_p0 && ew_p0;
  end

  // MEM -> WB register boundary
  logic              regwrite_p1;
  logic [REG_W-1:0]  writereg_p1;
  logic [DATA_W-1:0] writedata_p1;
  logic [CNT_W-1:0]  retire_cnt_p1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regwrite_p1  <= 1'b0;
      writereg_p1  <= '0;
      writedata_p1 <= '0;
    end else if (wb.wb_flush) begin
      regwrite_p1  <= 1'b0;
      writereg_p1  <= '0;
      writedata_p1 <= '0;
    end else if (load_p0) begin
      regwrite_p1  <= ew_p0;
      writereg_p1  <= wb.mem_Write_reg;
      writedata_p1 <= sel_p0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retire_cnt_p1 <= '0;
    end else if (push_p0) begin
      retire_cnt_p1 <= retire_cnt_p1 + 1'b1;
    end
  end

  assign wb.wb_RegWrite  = regwrite_p1;
  assign wb.wb_WriteReg  = writereg_p1;
  assign wb.wb_WriteData = writedata_p1;
  assign retire_count    = retire_cnt_p1;

`ifdef WB_TRACE_EN
  localparam int              PTR_W   = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;
  localparam logic [PTR_W:0]  DEPTH_C = (PTR_W + 1)'(TRACE_DEPTH);

  logic [TRACE_W-1:0] trace_mem [TRACE_DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W:0]     occ;
  logic               pop;
  logic               wr_en;
  logic               drop;
  logic               overflow_q;

  // A pop on the same edge frees the head slot, so a full FIFO still accepts the push.
  always_comb begin
    trace_empty = (occ == '0);
    trace_full  = (occ == DEPTH_C);
    pop         = trace_rd_en && !trace_empty;
    wr_en       = push_p0 && (!trace_full || pop);
    drop        = push_p0 && trace_full && !pop;
    trace_data  = trace_empty ? '0 : trace_mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      trace_mem[wr_ptr] <= {wb.mem_Write_reg, sel_p0};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      occ        <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
      if (drop) overflow_q <= 1'b1;
    end
  end

  assign trace_overflow = overflow_q;
`else
  logic unused_trace_rd_en;

  assign unused_trace_rd_en = trace_rd_en;
  assign trace_data         = '0;
  assign trace_empty        = 1'b1;
  assign trace_full         = 1'b0;
  assign trace_overflow     = 1'b0;
`endif

endmodule
